// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports, one write port, a debug read port
// and the committed-write counter.
interface reg_file_if;
  logic        RegWrite;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  imem_to_write_addr;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] write_count;

  modport master (
    output RegWrite, read_reg1, read_reg2, imem_to_write_addr, write_data, dbg_addr,
    input  read_data1, read_data2, dbg_data, write_count
  );

  modport slave (
    input  RegWrite, read_reg1, read_reg2, imem_to_write_addr, write_data, dbg_addr,
    output read_data1, read_data2, dbg_data, write_count
  );
endinterface

// File: rtl/reg_file.sv
// 32 x 32-bit MIPS-style register file: r0 hard-wired to zero, $gp/$sp reset values,
// optional write-first forwarding on the two read ports, and a committed-write counter.
module reg_file #(
  parameter logic [31:0] SP_RESET = 32'h0000_3FFC,
  parameter logic [31:0] GP_RESET = 32'h0000_1800,
  parameter bit          BYPASS   = 1'b1
) (
  input logic       clock,
  input logic       reset,
  reg_file_if.slave bus
);

  logic [31:0] regs [32];
  logic [15:0] count;
  logic        commit;
  logic        hit1;
  logic        hit2;

  function automatic logic [31:0] reset_value(input logic [4:0] idx);
    case (idx)
      5'd28:   return GP_RESET;
      5'd29:   return SP_RESET;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] read_port(input logic [4:0]  addr,
                                            input logic [31:0] stored,
                                            input logic        hit,
                                            input logic [31:0] fwd);
    if (addr == 5'd0) return 32'h0;
    if (hit)          return fwd;
    return stored;
  endfunction

  // A write only counts when it actually lands: reset wins and r0 swallows it.
  assign commit = bus.RegWrite && !reset && (bus.imem_to_write_addr != 5'd0);

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (BYPASS && commit) begin
      hit1 = (bus.read_reg1 == bus.imem_to_write_addr);
      hit2 = (bus.read_reg2 == bus.imem_to_write_addr);
    end
  end

  assign bus.read_data1  = read_port(bus.read_reg1, regs[bus.read_reg1], hit1, bus.write_data);
  assign bus.read_data2  = read_port(bus.read_reg2, regs[bus.read_reg2], hit2, bus.write_data);
  // Debug port observes storage only, so it shows the pre-edge value during a write.
  assign bus.dbg_data    = read_port(bus.dbg_addr, regs[bus.dbg_addr], 1'b0, 32'h0);
  assign bus.write_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= reset_value(5'(i));
      count <= 16'h0;
    end else if (commit) begin
      regs[bus.imem_to_write_addr] <= bus.write_data;
      count                        <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized checks of reg_file against an array-based reference model,
// with one forwarding and one non-forwarding instance driven identically.
module tb_reg_file;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] model [32];
  logic [15:0] mcount;

  reg_file_if bus0 ();
  reg_file_if bus1 ();

  assign bus1.RegWrite           = bus0.RegWrite;
  assign bus1.read_reg1          = bus0.read_reg1;
  assign bus1.read_reg2          = bus0.read_reg2;
  assign bus1.imem_to_write_addr = bus0.imem_to_write_addr;
  assign bus1.write_data         = bus0.write_data;
  assign bus1.dbg_addr           = bus0.dbg_addr;

  reg_file #(.BYPASS(1'b1)) dut_byp (.clock(clock), .reset(reset), .bus(bus0));
  reg_file #(.BYPASS(1'b0)) dut_nob (.clock(clock), .reset(reset), .bus(bus1));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && bus0.RegWrite && !reset && bus0.imem_to_write_addr != 5'd0 &&
        a == bus0.imem_to_write_addr)
      return bus0.write_data;
    return model[a];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da);
    bus0.RegWrite           = we;
    bus0.imem_to_write_addr = wa;
    bus0.write_data         = wd;
    bus0.read_reg1          = r1;
    bus0.read_reg2          = r2;
    bus0.dbg_addr           = da;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic check_all();
    check("byp_rd1", bus0.read_data1, exp_read(bus0.read_reg1, 1'b1));
    check("byp_rd2", bus0.read_data2, exp_read(bus0.read_reg2, 1'b1));
    check("nob_rd1", bus1.read_data1, exp_read(bus0.read_reg1, 1'b0));
    check("nob_rd2", bus1.read_data2, exp_read(bus0.read_reg2, 1'b0));
    check("byp_dbg", bus0.dbg_data, exp_read(bus0.dbg_addr, 1'b0));
    check("nob_dbg", bus1.dbg_data, exp_read(bus0.dbg_addr, 1'b0));
    check("byp_cnt", {16'h0, bus0.write_count}, {16'h0, mcount});
    check("nob_cnt", {16'h0, bus1.write_count}, {16'h0, mcount});
  endtask

  task automatic edge_step();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = 32'h0000_1800;
      model[29] = 32'h0000_3FFC;
      mcount = 16'h0;
    end else if (bus0.RegWrite && bus0.imem_to_write_addr != 5'd0) begin
      model[bus0.imem_to_write_addr] = bus0.write_data;
      mcount = mcount + 16'd1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] last;
    logic [4:0]  a;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    mcount = 16'hx;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    edge_step();
    edge_step();
    reset = 1'b0;

    // Post-reset contents of every register, on all read paths.
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      drive(1'b0, 5'd0, 32'h0, a, 5'(31 - i), a);
      settle();
      check_all();
      check("reset_dbg", bus0.dbg_data,
            (i == 28) ? 32'h0000_1800 : (i == 29) ? 32'h0000_3FFC : 32'h0);
      edge_step();
    end
    check("reset_cnt", {16'h0, bus0.write_count}, 32'h0);

    // Basic write then read on both ports.
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd8);
    settle(); check_all(); edge_step();
    drive(1'b0, 5'd8, 32'h0, 5'd8, 5'd8, 5'd8);
    settle(); check_all();
    check("wr_r8_rd1", bus0.read_data1, 32'hDEAD_BEEF);
    check("wr_r8_rd2", bus0.read_data2, 32'hDEAD_BEEF);
    check("wr_r8_cnt", {16'h0, bus0.write_count}, 32'd1);
    edge_step();

    // Writes to r0 vanish.
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    settle(); check_all(); edge_step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    settle(); check_all();
    check("r0_rd1", bus0.read_data1, 32'h0);
    check("r0_cnt", {16'h0, bus0.write_count}, 32'd1);
    edge_step();

    // Same-cycle write/read of r9: forwarding vs. old contents.
    drive(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9);
    settle(); check_all();
    check("byp_r9_rd1", bus0.read_data1, 32'hA5A5_A5A5);
    check("byp_r9_rd2", bus0.read_data2, 32'hA5A5_A5A5);
    check("byp_r9_dbg", bus0.dbg_data, 32'h0);
    check("nob_r9_rd1", bus1.read_data1, 32'h0);
    check("nob_r9_rd2", bus1.read_data2, 32'h0);
    edge_step();
    drive(1'b0, 5'd9, 32'h0, 5'd9, 5'd9, 5'd9);
    settle(); check_all();
    check("nob_r9_after", bus1.read_data1, 32'hA5A5_A5A5);
    edge_step();

    // Randomized traffic with occasional reset; addresses drawn narrow to force collisions.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7) + ((n % 2) ? 24 : 0)),
            $urandom(), 5'($urandom_range(0, 7) + ((n % 2) ? 24 : 0)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) bus0.read_reg2 = bus0.imem_to_write_addr;
      settle(); check_all(); edge_step();
    end
    reset = 1'b0;

    // Reset beats a simultaneous write; no forwarding during reset.
    drive(1'b1, 5'd5, 32'h0000_0077, 5'd0, 5'd0, 5'd0);
    settle(); edge_step();
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'h0000_0001, 5'd5, 5'd5, 5'd5);
    settle(); check_all();
    check("rst_nobyp", bus0.read_data1, 32'h0000_0077);
    edge_step();
    reset = 1'b0;
    drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd29, 5'd28);
    settle(); check_all();
    check("rst_r5", bus0.read_data1, 32'h0);
    check("rst_sp", bus0.read_data2, 32'h0000_3FFC);
    check("rst_gp", bus0.dbg_data, 32'h0000_1800);
    check("rst_cnt", {16'h0, bus0.write_count}, 32'h0);
    edge_step();

    // 65536 writes to r3 wrap the counter back to zero.
    last = 32'h0;
    for (int i = 0; i < 65536; i++) begin
      last = $urandom();
      drive(1'b1, 5'd3, last, 5'd3, 5'd3, 5'd3);
      if (i == 65535) begin
        settle();
        check("wrap_ffff", {16'h0, bus0.write_count}, 32'h0000_FFFF);
      end
      edge_step();
    end
    drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd3, 5'd3);
    settle(); check_all();
    check("wrap_cnt", {16'h0, bus0.write_count}, 32'h0);
    check("wrap_r3", bus0.dbg_data, last);
    edge_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
